// File: rtl/instr_register_pipe.sv
// rtl/instr_register_pipe.sv - instruction store with registered ALU write-back and a forwarding read port
// Build option INSTR_REG_AUTO_INC_EN: loads take their address from the internal wrapping wr_ptr_q.
module instr_register_pipe #(
  parameter  int DEPTH  = 32,
  parameter  int OP_W   = 32,
  parameter  int RES_W  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [3:0]               opcode,
  input  logic signed [OP_W-1:0]   operand_a,
  input  logic signed [OP_W-1:0]   operand_b,
  input  logic [ADDR_W-1:0]        write_pointer,
  input  logic                     read_en,
  input  logic [ADDR_W-1:0]        read_pointer,
  output logic                     rd_valid,
  output logic                     rd_hit,
  output logic [3:0]               rd_opcode,
  output logic signed [OP_W-1:0]   rd_operand_a,
  output logic signed [OP_W-1:0]   rd_operand_b,
  output logic signed [RES_W-1:0]  rd_result,
  output logic                     rd_err,
  output logic [ADDR_W-1:0]        wr_ptr_q
);

  typedef enum logic [3:0] {
    OP_ZERO  = 4'd0,
    OP_PASSA = 4'd1,
    OP_PASSB = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_MULT  = 4'd5,
    OP_DIV   = 4'd6,
    OP_MOD   = 4'd7
  } opcode_e;

  logic [ADDR_W-1:0]       load_addr;
  logic                    s1_valid;
  logic [ADDR_W-1:0]       s1_addr;
  logic [3:0]              s1_opcode;
  logic signed [OP_W-1:0]  s1_a;
  logic signed [OP_W-1:0]  s1_b;

`ifdef INSTR_REG_AUTO_INC_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
    end else if (load_en) begin
      wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
    end
  end
  assign load_addr = wr_ptr_q;
`else
  assign wr_ptr_q  = '0;
  assign load_addr = write_pointer;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_opcode <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else begin
      s1_valid <= load_en;
      if (load_en) begin
        s1_addr   <= load_addr;
        s1_opcode <= opcode;
        s1_a      <= operand_a;
        s1_b      <= operand_b;
      end
    end
  end

  // Operands widened to RES_W so ADD/SUB and the MIN/-1 divide cannot overflow.
  logic signed [RES_W-1:0]  ext_a;
  logic signed [RES_W-1:0]  ext_b;
  logic signed [2*OP_W-1:0] product;
  logic signed [RES_W-1:0]  alu_result;
  logic                     alu_err;

  assign ext_a   = {{(RES_W-OP_W){s1_a[OP_W-1]}}, s1_a};
  assign ext_b   = {{(RES_W-OP_W){s1_b[OP_W-1]}}, s1_b};
  assign product = s1_a * s1_b;

  always_comb begin
    alu_result = '0;
    alu_err    = 1'b0;
    case (s1_opcode)
      OP_ZERO:  alu_result = '0;
      OP_PASSA: alu_result = ext_a;
      OP_PASSB: alu_result = ext_b;
      OP_ADD:   alu_result = ext_a + ext_b;
      OP_SUB:   alu_result = ext_a - ext_b;
      OP_MULT:  alu_result = RES_W'(product);
      OP_DIV: begin
        if (s1_b == '0) alu_err = 1'b1;
        else            alu_result = ext_a / ext_b;
      end
      OP_MOD: begin
        if (s1_b == '0) alu_err = 1'b1;
        else            alu_result = ext_a % ext_b;
      end
      default:  alu_err = 1'b1;
    endcase
  end

  logic [DEPTH-1:0]       entry_valid;
  logic [DEPTH-1:0]       mem_err;
  logic [3:0]             mem_opcode [DEPTH];
  logic [OP_W-1:0]        mem_a      [DEPTH];
  logic [OP_W-1:0]        mem_b      [DEPTH];
  logic [RES_W-1:0]       mem_result [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_valid <= '0;
    end else if (s1_valid) begin
      entry_valid[s1_addr] <= 1'b1;
    end
  end

  // Data arrays carry no reset; entry_valid masks them on the read side.
  always_ff @(posedge clk) begin
    if (!reset && s1_valid) begin
      mem_opcode[s1_addr] <= s1_opcode;
      mem_a[s1_addr]      <= s1_a;
      mem_b[s1_addr]      <= s1_b;
      mem_result[s1_addr] <= alu_result;
      mem_err[s1_addr]    <= alu_err;
    end
  end

  logic fwd_hit;
  assign fwd_hit = s1_valid && (s1_addr == read_pointer);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid     <= 1'b0;
      rd_hit       <= 1'b0;
      rd_opcode    <= '0;
      rd_operand_a <= '0;
      rd_operand_b <= '0;
      rd_result    <= '0;
      rd_err       <= 1'b0;
    end else begin
      rd_valid <= read_en;
      if (read_en) begin
        if (fwd_hit) begin
          rd_hit       <= 1'b1;
          rd_opcode    <= s1_opcode;
          rd_operand_a <= s1_a;
          rd_operand_b <= s1_b;
          rd_result    <= alu_result;
          rd_err       <= alu_err;
        end else if (entry_valid[read_pointer]) begin
          rd_hit       <= 1'b1;
          rd_opcode    <= mem_opcode[read_pointer];
          rd_operand_a <= mem_a[read_pointer];
          rd_operand_b <= mem_b[read_pointer];
          rd_result    <= mem_result[read_pointer];
          rd_err       <= mem_err[read_pointer];
        end else begin
          rd_hit       <= 1'b0;
          rd_opcode    <= '0;
          rd_operand_a <= '0;
          rd_operand_b <= '0;
          rd_result    <= '0;
          rd_err       <= 1'b0;
        end
      end
    end
  end

endmodule
